xor_tree_fault_monitor: RTL and testbench

- Parametrised laser fault-injection target: a WIDTH-input registered XOR tree (the target) plus an independently built golden parity path.
- Both paths are compared every cycle, with a sticky fault flag and a saturating fault counter.
- One input is driven by an internal, programmable-rate toggle generator, so the target can be located by its switching activity without an external differential clock.
- Sits between the board I/O wrapper and the UART/readout logic.

---
 rtl/xor_tree_fault_monitor.sv | 163 ++++++++++++++++
 tb/tb_xor_tree_fault_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_tree_fault_monitor.sv
// Laser fault-injection target: registered XOR tree, independent golden parity path,
// mismatch FSM with sticky flag and saturating counter. Optional capture: XOR_FAULT_CAPTURE_EN.
module xor_tree_fault_monitor #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [WIDTH-2:0] a,
    input  logic             osc_en,
    input  logic [DIV_W-1:0] div,
    input  logic             arm,
    input  logic             clear,
    output logic             q,
    output logic             golden,
    output logic             fault,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [1:0]       state
`ifdef XOR_FAULT_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] fault_vec,
    output logic [31:0]      fault_time
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        WATCH   = 2'd2,
        FAULTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic               settle_cnt;
    logic               tgl;
    logic [DIV_W-1:0]   div_cnt;
    logic [WIDTH-1:0]   in_r;
    logic               mismatch;
    logic               count_en;
    logic               first_hit;

    // Target and golden are built separately so the fault only hits one of them.
    (* dont_touch = "true" *) logic tgt_xor;
    (* dont_touch = "true" *) logic gold_par;

    assign tgt_xor = ^in_r;

    always_comb begin
        gold_par = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            gold_par = gold_par ^ in_r[i];
        end
    end

    // Toggle generator: half-period is div+1 cycles; counter parks at 0 when disabled.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            tgl     <= 1'b0;
            div_cnt <= '0;
        end else if (osc_en) begin
            if (div_cnt == div) begin
                tgl     <= ~tgl;
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else begin
            div_cnt <= '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            in_r   <= '0;
            q      <= 1'b0;
            golden <= 1'b0;
        end else begin
            in_r   <= {tgl, a};
            q      <= tgt_xor;
            golden <= gold_par;
        end
    end

    assign mismatch = (q != golden);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_cnt <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_cnt <= (state_q == SETTLE && state_d == SETTLE) ? 1'b1 : 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (arm) state_d = SETTLE;
                SETTLE:  if (!arm) state_d = IDLE;
                         else if (settle_cnt) state_d = WATCH;
                WATCH:   if (!arm) state_d = IDLE;
                         else if (mismatch) state_d = FAULTED;
                FAULTED: if (!arm) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_en  = 1'b0;
        first_hit = 1'b0;
        if (!clear && arm && (state_q == WATCH || state_q == FAULTED)) begin
            count_en  = mismatch;
            first_hit = mismatch && (state_q == WATCH);
        end
    end

    assign state = state_q;

    always_ff @(posedge sysclk) begin
        if (rst || clear) begin
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else if (count_en) begin
            fault <= 1'b1;
            if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + 1'b1;
        end
    end

`ifdef XOR_FAULT_CAPTURE_EN
    logic [31:0]      tstamp;
    logic [WIDTH-1:0] in_r_d;

    // in_r_d lines up with the q/golden pair being compared this cycle.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            tstamp <= '0;
            in_r_d <= '0;
        end else begin
            tstamp <= tstamp + 32'd1;
            in_r_d <= in_r;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst || clear) begin
            fault_vec  <= '0;
            fault_time <= '0;
        end else if (first_hit) begin
            fault_vec  <= in_r_d;
            fault_time <= tstamp;
        end
    end
`endif

endmodule

// File: tb/tb_xor_tree_fault_monitor.sv
// Directed bench for xor_tree_fault_monitor: parity scoreboard plus FSM/counter checks,
// with a CNT_W=4 instance alongside for saturation.
module tb_xor_tree_fault_monitor;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [4:0]  a;
  logic        osc_en;
  logic [7:0]  div;
  logic        arm;
  logic        clear;
  logic        q, golden, fault;
  logic [15:0] fault_cnt;
  logic [1:0]  state;
  logic        q4, golden4, fault4;
  logic [3:0]  fault_cnt4;
  logic [1:0]  state4;
`ifdef XOR_FAULT_CAPTURE_EN
  logic [5:0]  fault_vec, fault_vec4;
  logic [31:0] fault_time, fault_time4;
`endif

  always #5 sysclk = ~sysclk;

  xor_tree_fault_monitor #(.WIDTH(6), .CNT_W(16), .DIV_W(8)) dut (
    .sysclk(sysclk), .rst(rst), .a(a), .osc_en(osc_en), .div(div), .arm(arm), .clear(clear),
    .q(q), .golden(golden), .fault(fault), .fault_cnt(fault_cnt), .state(state)
`ifdef XOR_FAULT_CAPTURE_EN
    , .fault_vec(fault_vec), .fault_time(fault_time)
`endif
  );

  xor_tree_fault_monitor #(.WIDTH(6), .CNT_W(4), .DIV_W(8)) dut4 (
    .sysclk(sysclk), .rst(rst), .a(a), .osc_en(osc_en), .div(div), .arm(arm), .clear(clear),
    .q(q4), .golden(golden4), .fault(fault4), .fault_cnt(fault_cnt4), .state(state4)
`ifdef XOR_FAULT_CAPTURE_EN
    , .fault_vec(fault_vec4), .fault_time(fault_time4)
`endif
  );

  logic        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        tgl_m = 1'b0;
  logic [7:0]  cnt_m = '0;
  int          ts_m = 0;
  logic        chk_q = 1'b1;
  logic        chk_nofault = 1'b0;
  logic        p_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: push the parity in_r will take at this edge, then score q/golden.
  task automatic tick();
    logic e;
    if (!rst) exp_q.push_back(^{tgl_m, a});
    if (rst) begin
      tgl_m = 1'b0;
      cnt_m = '0;
    end else if (osc_en) begin
      if (cnt_m == div) begin
        tgl_m = ~tgl_m;
        cnt_m = '0;
      end else begin
        cnt_m = cnt_m + 8'd1;
      end
    end else begin
      cnt_m = '0;
    end
    @(posedge sysclk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(1'b0);
      ts_m = 0;
    end else begin
      ts_m++;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        if (chk_q) begin
          check("q", {31'd0, q}, {31'd0, e});
          check("q4", {31'd0, q4}, {31'd0, e});
        end
        check("golden", {31'd0, golden}, {31'd0, e});
        check("golden4", {31'd0, golden4}, {31'd0, e});
      end
      if (chk_nofault) check("nofault", {31'd0, fault}, 32'd0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic force_tree(input logic v);
    force dut.tgt_xor = v;
    force dut4.tgt_xor = v;
    chk_q = 1'b0;
  endtask

  task automatic release_tree();
    release dut.tgt_xor;
    release dut4.tgt_xor;
    chk_q = 1'b1;
  endtask

  initial begin
    rst = 1'b1; a = '0; osc_en = 1'b0; div = 8'd3; arm = 1'b0; clear = 1'b0;
    ticks(2);
    check("rst_q", {31'd0, q}, 32'd0);
    check("rst_golden", {31'd0, golden}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_cnt", {16'd0, fault_cnt}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    rst = 1'b0;

    // Static pattern, toggle off: parity of {0,00111} is 1.
    a = 5'b00111;
    ticks(3);
    check("static_q", {31'd0, q}, 32'd1);
    check("static_state", {30'd0, state}, 32'd0);

    // Toggle running, armed, random traffic: never a fault.
    osc_en = 1'b1; div = 8'd3; arm = 1'b1;
    tick(); check("arm_settle0", {30'd0, state}, 32'd1);
    tick(); check("arm_settle1", {30'd0, state}, 32'd1);
    tick(); check("arm_watch", {30'd0, state}, 32'd2);
    chk_nofault = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) a = 5'($urandom_range(0, 31));
      tick();
    end
    chk_nofault = 1'b0;
    check("run_state", {30'd0, state}, 32'd2);
    check("run_cnt", {16'd0, fault_cnt}, 32'd0);

    // Three-cycle inverted target.
    osc_en = 1'b0; a = 5'b01101;
    ticks(3);
    p_hold = ^{tgl_m, a};
    force_tree(~p_hold);
    ticks(3);
    release_tree();
    tick();
    check("f3_fault", {31'd0, fault}, 32'd1);
    check("f3_cnt", {16'd0, fault_cnt}, 32'd3);
    check("f3_state", {30'd0, state}, 32'd3);
    tick();
    check("f3_cnt_hold", {16'd0, fault_cnt}, 32'd3);
    arm = 1'b0;
    tick();
    check("disarm_state", {30'd0, state}, 32'd0);
    check("disarm_cnt", {16'd0, fault_cnt}, 32'd3);
    check("disarm_fault", {31'd0, fault}, 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_cnt", {16'd0, fault_cnt}, 32'd0);
    check("clr_fault", {31'd0, fault}, 32'd0);

    // Continuous mismatch for 20 cycles: 4-bit counter saturates at 15.
    arm = 1'b1;
    ticks(3);
    check("sat_watch", {30'd0, state}, 32'd2);
    p_hold = ^{tgl_m, a};
    force_tree(~p_hold);
    ticks(20);
    release_tree();
    tick();
    check("sat_cnt4", {28'd0, fault_cnt4}, 32'd15);
    check("sat_fault4", {31'd0, fault4}, 32'd1);
    check("sat_state4", {30'd0, state4}, 32'd3);
    check("sat_cnt16", {16'd0, fault_cnt}, 32'd20);

    // arm together with clear: clear wins, re-arm once clear drops.
    clear = 1'b1; tick(); clear = 1'b0;
    check("armclr_state", {30'd0, state}, 32'd0);
    check("armclr_cnt", {16'd0, fault_cnt}, 32'd0);
    check("armclr_cnt4", {28'd0, fault_cnt4}, 32'd0);
    tick();
    check("rearm_state", {30'd0, state}, 32'd1);
    ticks(2);
    check("rearm_watch", {30'd0, state}, 32'd2);

    // Mismatch lands on the same edge as clear: not counted.
    p_hold = ^{tgl_m, a};
    force_tree(~p_hold);
    tick();
    release_tree();
    clear = 1'b1; tick(); clear = 1'b0; arm = 1'b0;
    check("mmclr_cnt", {16'd0, fault_cnt}, 32'd0);
    check("mmclr_fault", {31'd0, fault}, 32'd0);
    check("mmclr_state", {30'd0, state}, 32'd0);
    tick();
    check("mmclr_after", {16'd0, fault_cnt}, 32'd0);

    // arm high through reset: SETTLE only after reset drops.
    rst = 1'b1; arm = 1'b1; a = 5'b11111;
    ticks(2);
    check("rstarm_state", {30'd0, state}, 32'd0);
    check("rstarm_q", {31'd0, q}, 32'd0);
    check("rstarm_golden", {31'd0, golden}, 32'd0);
    check("rstarm_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    tick();
    check("rstarm_settle", {30'd0, state}, 32'd1);

`ifdef XOR_FAULT_CAPTURE_EN
    check("cap_rst_vec", {26'd0, fault_vec}, 32'd0);
    check("cap_rst_time", fault_time, 32'd0);
    a = 5'b10101; osc_en = 1'b1; div = 8'd0;
    tick();
    osc_en = 1'b0;
    while (ts_m < 99) tick();
    p_hold = ^{tgl_m, a};
    force_tree(~p_hold);
    tick();
    release_tree();
    tick();
    check("cap_vec", {26'd0, fault_vec}, 32'h35);
    check("cap_time", fault_time, 32'd100);
    while (ts_m < 149) tick();
    force_tree(~p_hold);
    tick();
    release_tree();
    tick();
    check("cap2_cnt", {16'd0, fault_cnt}, 32'd2);
    check("cap2_vec", {26'd0, fault_vec}, 32'h35);
    check("cap2_time", fault_time, 32'd100);
`endif

    ticks(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
